// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int CODE_W = 4;
    localparam int ROW_W  = 2;
    localparam int COL_W  = 2;

    // Debounce FSM states
    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        PRESSED,
        RELEASE
    } state_e;

    // Outcome of one full four-row scan
    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_SINGLE,
        SCAN_MULTI
    } scan_res_e;

    // Note code of a key: row index in the upper bits, column index in the lower bits
    function automatic logic [CODE_W-1:0] key_code(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/keypad_row_scanner.sv
// Row drive, column synchronizer and per-scan NONE/SINGLE/MULTI classification.
module keypad_row_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 5000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [COLS-1:0]   col_in,
    output logic [ROWS-1:0]   row_out,
    output logic              scan_done,
    output scan_res_e         scan_res,
    output logic [CODE_W-1:0] scan_code
);

    localparam int                SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

    logic [COLS-1:0]   sync1_q, sync2_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [ROW_W-1:0]  row_q, row_d;
    // hits_q counts intersections seen so far in this scan, saturating at 2
    logic [1:0]        hits_q, hits_d;
    logic [CODE_W-1:0] code_q, code_d;

    logic              slot_end;
    logic [COLS-1:0]   col_low;
    logic [2:0]        row_hits;
    logic [COL_W-1:0]  low_idx;
    logic [3:0]        hit_sum;
    logic [1:0]        total_hits;
    logic [CODE_W-1:0] total_code;

    // One-hot active-low row drive; all rows released while disabled
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_drive
        assign row_out[gi] = !(enable && (row_q == ROW_W'(gi)));
    end

    // Two-flop synchronizer for the asynchronous column inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= col_in;
            sync2_q <= sync1_q;
        end
    end

    // Classify the current row sample and fold it into the running scan result
    always_comb begin
        col_low  = ~sync2_q;
        row_hits = '0;
        low_idx  = '0;
        for (int i = 0; i < COLS; i++) begin
            row_hits = row_hits + 3'(col_low[i]);
            if (col_low[i]) begin
                low_idx = COL_W'(i);
            end
        end
        hit_sum    = {2'b00, hits_q} + {1'b0, row_hits};
        total_hits = (hit_sum >= 4'd2) ? 2'd2 : hit_sum[1:0];
        total_code = ((hits_q == 2'd0) && (row_hits == 3'd1)) ? key_code(row_q, low_idx) : code_q;

        slot_end  = enable && (slot_q == SLOT_LAST);
        scan_done = slot_end && (row_q == ROW_LAST);
        scan_code = total_code;
        case (total_hits)
            2'd0:    scan_res = SCAN_NONE;
            2'd1:    scan_res = SCAN_SINGLE;
            default: scan_res = SCAN_MULTI;
        endcase
    end

    // Slot/row counters and accumulator next state
    always_comb begin
        slot_d = slot_q;
        row_d  = row_q;
        hits_d = hits_q;
        code_d = code_q;
        if (!enable) begin
            slot_d = '0;
            row_d  = '0;
            hits_d = '0;
            code_d = '0;
        end else if (slot_end) begin
            slot_d = '0;
            row_d  = row_q + 1'b1;
            if (row_q == ROW_LAST) begin
                // Scan complete: result leaves on scan_done, start fresh
                hits_d = '0;
                code_d = '0;
            end else begin
                hits_d = total_hits;
                code_d = total_code;
            end
        end else begin
            slot_d = slot_q + 1'b1;
        end
    end

    // Counter and accumulator registers
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= '0;
            row_q  <= '0;
            hits_q <= '0;
            code_q <= '0;
        end else begin
            slot_q <= slot_d;
            row_q  <= row_d;
            hits_q <= hits_d;
            code_q <= code_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: debounces scan results and strobes accepted key codes.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 5000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [COLS-1:0]   col_in,
    output logic [ROWS-1:0]   row_out,
    output logic [CODE_W-1:0] keypad_data,
    output logic              keypad_enable,
    output logic              key_held
);

    localparam int               CNT_W    = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);

    logic              scan_done;
    scan_res_e         scan_res;
    logic [CODE_W-1:0] scan_code;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CODE_W-1:0] data_q, data_d;
    logic              strobe_q, strobe_d;

    keypad_row_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_row_scanner (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .col_in    (col_in),
        .row_out   (row_out),
        .scan_done (scan_done),
        .scan_res  (scan_res),
        .scan_code (scan_code)
    );

    // Debounce FSM: advances once per completed scan
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        cnt_inc  = cnt_q + 1'b1;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (scan_done) begin
            case (state_q)
                IDLE: begin
                    if (scan_res == SCAN_SINGLE) begin
                        cand_d = scan_code;
                        if (CNT_ONE == CNT_LAST) begin
                            state_d  = PRESSED;
                            cnt_d    = '0;
                            data_d   = scan_code;
                            strobe_d = 1'b1;
                        end else begin
                            state_d = CONFIRM;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                CONFIRM: begin
                    if (scan_res == SCAN_SINGLE) begin
                        if (scan_code == cand_q) begin
                            if (cnt_inc == CNT_LAST) begin
                                state_d  = PRESSED;
                                cnt_d    = '0;
                                data_d   = cand_q;
                                strobe_d = 1'b1;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end else begin
                            cand_d = scan_code;
                            cnt_d  = CNT_ONE;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (scan_res == SCAN_NONE) begin
                        // A single NONE scan already completes release when one scan suffices
                        if (CNT_ONE == CNT_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (scan_res == SCAN_NONE) begin
                        if (cnt_inc == CNT_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cand_q   <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    assign keypad_data   = data_q;
    assign keypad_enable = strobe_q;
    assign key_held      = (state_q == PRESSED) || (state_q == RELEASE);

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad and is the producer side of the game block's keypad interface. It drives the rows, samples the columns and debounces each press. Every debounced press is delivered to the game block as a 4-bit note code on `keypad_data`, together with a one-clock `keypad_enable` strobe. It sits between the board keypad pins and the game block.

## Interface
- `SCAN_DIV`, default 5000: clocks each row stays driven. Minimum 4.
- `DEBOUNCE_SCANS`, default 4: number of consecutive identical full scans needed to accept a press or a release. Minimum 1.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: scanner runs only while this is high.
- `col_in` in 4: keypad columns, active-low, pulled up on the board. Asynchronous.
- `row_out` out 4: row drive, active-low, one-hot.
- `keypad_data` out 4: code of the most recently accepted key. Held until the next accepted press.
- `keypad_enable` out 1: one-clock strobe. `keypad_data` is already valid in the same cycle.
- `key_held` out 1: high while an accepted key is held (states PRESSED and RELEASE).

## Operation
- `col_in` passes through a 2-flop synchronizer. All logic below uses only the synchronized value.
- Row counter `r` runs 0..3.
  - Each row slot lasts `SCAN_DIV` clocks; `row_out = ~(1<<r)` during the slot.
  - The synchronized columns are sampled on the last clock of the slot.
  - `r` wraps 3->0, so one full scan takes `4*SCAN_DIV` clocks.
- Scan result, computed from the four row samples:
  - NONE: no column is low in any row.
  - SINGLE(code): exactly one row/column intersection is low. `code = {r[1:0], c[1:0]}`, where c is the index of the low column.
  - MULTI: two or more intersections are low.
- FSM, evaluated once per scan at scan end:
  - IDLE: SINGLE(k) -> CONFIRM with cand=k, cnt=1. NONE or MULTI -> stay in IDLE.
  - CONFIRM: SINGLE(cand) -> cnt+1. If cnt reaches `DEBOUNCE_SCANS`, go to PRESSED, load `keypad_data`=cand and pulse `keypad_enable`. SINGLE of a different key -> restart CONFIRM with the new cand, cnt=1. NONE or MULTI -> IDLE.
  - PRESSED: NONE -> RELEASE with cnt=1. SINGLE or MULTI -> stay in PRESSED. A held key never re-strobes.
  - RELEASE: NONE -> cnt+1. If cnt reaches `DEBOUNCE_SCANS`, go to IDLE. SINGLE or MULTI -> PRESSED.
- When `DEBOUNCE_SCANS`=1, the first SINGLE scan in IDLE goes straight to PRESSED and strobes.
- `enable` low:
  - `row_out`=4'b1111, row counter and slot counter cleared.
  - FSM forced to IDLE, no strobe.
  - `keypad_data` keeps its value.
- `enable` rising: scanning restarts at row 0. A key already held is accepted after `DEBOUNCE_SCANS` scans and strobed once.
- Counter widths: slot counter `$clog2(SCAN_DIV)` bits, cnt `$clog2(DEBOUNCE_SCANS+1)` bits. All comparisons are unsigned with no overflow.

## Timing
- Reset values:
  - `row_out`=4'b1110 (row 0 driven).
  - `keypad_data`=0, `keypad_enable`=0, `key_held`=0.
  - FSM=IDLE, all counters 0, synchronizer flops 4'b1111.
- Reset applied mid-press behaves like power-up. A key still held afterwards is reported again after debounce.
- `keypad_enable` rises on the clock after the scan-end sample that completes confirmation, and stays high for exactly 1 clock.
- `key_held` rises in the same cycle as `keypad_enable`.
- Worst-case latency from a stable press to the strobe is `(DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3` clocks.
- A column change must persist for at least 2 clocks before the sample clock to be seen. `SCAN_DIV`>=4 guarantees settling after each row switch.
- Because the FSM reacts only at scan boundaries, a press and a release inside the same scan count as a NONE scan.

## Structure
- Package `keypad_pkg` holds:
  - State enum {IDLE, CONFIRM, PRESSED, RELEASE}.
  - Constants ROWS=4, COLS=4, CODE_W=4.
  - Function encoding row/col to code.
- Sub-module `keypad_row_scanner` contains the row/slot counters, the column synchronizer and the per-scan NONE/SINGLE/MULTI result. It outputs a one-clock `scan_done` pulse with the result.
- The top level holds the debounce FSM and the output registers.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE_SCANS`=3, so one scan is 16 clocks. The bench models the keypad matrix.
- Hold row2/col1 for 10 scans, then release -> exactly one strobe with `keypad_data`=9. `key_held` high from the strobe until 3 NONE scans after release.
- Bounce row0/col3 (held 1 scan, released 1 scan, repeated 3 times), then hold 3 scans -> a single strobe with code 3, only after the stable hold.
- Hold row0/col0 and row3/col3 together for 8 scans -> no strobe. Then release row3/col3 -> strobe with code 0 after 3 scans.
- Press code 5, release for 3 scans, press code 5 again -> two strobes. Release of only 2 scans between presses -> one strobe.
- Assert `reset` for 1 clock while code 12 is held in PRESSED -> all outputs take their reset values. Strobe with code 12 again 3 scans later.
- `enable`=0 while a key is held -> `row_out`=4'b1111 and no strobe. `enable` set to 1 -> one strobe after 3 scans.
